asmd_booth_multiplier: RTL and testbench

Parametrised sequential multiplier built as an ASMD datapath/controller pair. It supports signed (two's-complement) and unsigned operands using radix-2 Booth recoding, with a start/ready/done handshake. It succeeds the fixed-width unsigned ASMD multiplier in the synthesis block set. The block adds runtime signed/unsigned mode, a registered product that is held stable while a multiply is running, and back-to-back operation.

---
 rtl/asmd_booth_multiplier.sv | 101 ++++++++++
 tb/tb_asmd_booth_multiplier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/asmd_booth_multiplier.sv
// Sequential radix-2 Booth multiplier (ASMD controller + datapath) for signed or
// unsigned W-bit operands; W+1 iterations per product with a start/ready/done handshake.
module asmd_booth_multiplier #(
   parameter int word_length = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       signed_mode,
   input  logic [word_length-1:0]     word0,
   input  logic [word_length-1:0]     word1,
   output logic [2*word_length-1:0]   product,
   output logic                       ready,
   output logic                       done
);

   localparam int W     = word_length;
   localparam int CNT_W = $clog2(W + 2);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [W+1:0]     acc, acc_nxt, addend, sum;
   logic [W:0]       mcand, mq, mq_nxt;
   logic             q_m1, q_m1_nxt;
   logic [CNT_W-1:0] cnt;
   logic             load, last;

   // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      last      = (cnt == CNT_W'(1));
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            load  = start;
            state_nxt = start ? BUSY : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One Booth step: conditional add/subtract of the sign-extended multiplicand,
   // then arithmetic shift of {acc, mq, q_m1}.
   always_comb begin
      addend = {mcand[W], mcand};
      case ({mq[0], q_m1})
         2'b01:   sum = acc + addend;
         2'b10:   sum = acc - addend;
         default: sum = acc;
      endcase
      acc_nxt  = {sum[W+1], sum[W+1:1]};
      mq_nxt   = {sum[0], mq[W:1]};
      q_m1_nxt = mq[0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         mq      <= '0;
         mcand   <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         mcand <= {signed_mode & word0[W-1], word0};
         mq    <= {signed_mode & word1[W-1], word1};
         acc   <= '0;
         q_m1  <= 1'b0;
         cnt   <= CNT_W'(W + 1);
      end else if (state == BUSY) begin
         acc  <= acc_nxt;
         mq   <= mq_nxt;
         q_m1 <= q_m1_nxt;
         cnt  <= cnt - CNT_W'(1);
         // Low 2W bits of the 2(W+1)-bit result are exact in both modes.
         if (last) product <= {acc_nxt[W-2:0], mq_nxt};
      end
   end

endmodule

// File: tb/tb_asmd_booth_multiplier.sv
// Self-checking bench for asmd_booth_multiplier: directed W=4 scenarios and
// random W=8 pairs, with expected products queued at accept and compared at done.
module tb_asmd_booth_multiplier;

   logic        clk, reset;
   logic        s4, sm4, r4, d4;
   logic [3:0]  w0_4, w1_4;
   logic [7:0]  p4;
   logic        s8, sm8, r8, d8;
   logic [7:0]  w0_8, w1_8;
   logic [15:0] p8;

   logic        sel;
   logic        cur_ready, cur_done;
   logic [15:0] cur_p;
   logic [15:0] exp_q[$];
   logic [15:0] last_p, got;
   int          n_checks = 0;
   int          n_fail   = 0;

   asmd_booth_multiplier #(.word_length(4)) dut4 (
      .clk(clk), .reset(reset), .start(s4), .signed_mode(sm4),
      .word0(w0_4), .word1(w1_4), .product(p4), .ready(r4), .done(d4));

   asmd_booth_multiplier #(.word_length(8)) dut8 (
      .clk(clk), .reset(reset), .start(s8), .signed_mode(sm8),
      .word0(w0_8), .word1(w1_8), .product(p8), .ready(r8), .done(d8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      cur_p     = sel ? p8 : {8'h00, p4};
      cur_ready = sel ? r8 : r4;
      cur_done  = sel ? d8 : d4;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input int w, input logic sm,
                                         input logic [7:0] a, input logic [7:0] b);
      longint ai, bi, p;
      ai = longint'(a) & ((64'sd1 << w) - 1);
      bi = longint'(b) & ((64'sd1 << w) - 1);
      if (sm && ai[w-1]) ai = ai - (64'sd1 << w);
      if (sm && bi[w-1]) bi = bi - (64'sd1 << w);
      p = ai * bi;
      return 16'(p & ((64'sd1 << (2 * w)) - 1));
   endfunction

   task automatic drive(input logic s, input logic sm, input logic [7:0] a, input logic [7:0] b);
      if (sel) begin
         s8 = s; sm8 = sm; w0_8 = a; w1_8 = b;
      end else begin
         s4 = s; sm4 = sm; w0_4 = a[3:0]; w1_4 = b[3:0];
      end
   endtask

   // Returns at the negedge right after the accepting edge.
   task automatic start_op(input logic sm, input logic [7:0] a, input logic [7:0] b);
      drive(1'b1, sm, a, b);
      @(negedge clk);
      exp_q.push_back(model(sel ? 8 : 4, sm, a, b));
      if (sel) s8 = 1'b0; else s4 = 1'b0;
   endtask

   task automatic finish(input string tag, input int exp_busy, input logic [15:0] held,
                         output logic [15:0] e);
      int busy = 0;
      int cyc  = 0;
      while (!cur_done && cyc < 40) begin
         if (!cur_ready) busy++;
         check($sformatf("%s held", tag), 32'(cur_p), 32'(held));
         @(negedge clk);
         cyc++;
      end
      check($sformatf("%s timeout", tag), 32'(cyc < 40), 32'd1);
      check($sformatf("%s busy", tag), busy, exp_busy);
      e = exp_q.pop_front();
      check($sformatf("%s product", tag), 32'(cur_p), 32'(e));
   endtask

   task automatic op(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] e;
      start_op(sm, a, b);
      finish(tag, sel ? 9 : 5, last_p, e);
      last_p = e;
      @(negedge clk);
      check($sformatf("%s done pulse", tag), 32'(cur_done), 32'd0);
      check($sformatf("%s ready", tag), 32'(cur_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; last_p = '0;
      s4 = 1'b0; sm4 = 1'b0; w0_4 = '0; w1_4 = '0;
      s8 = 1'b0; sm8 = 1'b0; w0_8 = '0; w1_8 = '0;

      // Reset with start held high: reset must win.
      reset = 1'b1;
      drive(1'b1, 1'b0, 8'h05, 8'h03);
      @(negedge clk);
      @(negedge clk);
      check("reset product4", 32'(p4), 32'd0);
      check("reset ready4", 32'(r4), 32'd1);
      check("reset done4", 32'(d4), 32'd0);
      check("reset product8", 32'(p8), 32'd0);
      reset = 1'b0;
      s4 = 1'b0;
      @(negedge clk);
      check("post reset ready4", 32'(r4), 32'd1);

      op("u 8x15", 1'b0, 8'h08, 8'h0F);
      check("u 8x15 const", 32'(last_p), 32'h78);
      op("s -8x-1", 1'b1, 8'h08, 8'h0F);
      check("s -8x-1 const", 32'(last_p), 32'h08);
      op("s -8x-8", 1'b1, 8'h08, 8'h08);
      op("s 7x-8", 1'b1, 8'h07, 8'h08);
      check("s 7x-8 const", 32'(last_p), 32'hC8);
      op("u 15x15", 1'b0, 8'h0F, 8'h0F);
      op("u 0x13", 1'b0, 8'h00, 8'h0D);

      // Back-to-back: start held in DONE, next result exactly W+2 cycles later.
      start_op(1'b0, 8'h02, 8'h07);
      finish("b2b first", 5, last_p, got);
      last_p = got;
      drive(1'b1, 1'b0, 8'h03, 8'h05);
      @(negedge clk);
      exp_q.push_back(model(4, 1'b0, 8'h03, 8'h05));
      s4 = 1'b0;
      check("b2b accepted", 32'(r4), 32'd0);
      check("b2b done low", 32'(d4), 32'd0);
      finish("b2b second", 5, last_p, got);
      last_p = got;
      check("b2b const", 32'(last_p), 32'h0F);
      @(negedge clk);
      check("b2b done pulse", 32'(d4), 32'd0);

      // Inputs and start toggled while BUSY must be ignored.
      start_op(1'b0, 8'h0B, 8'h03);
      check("ign busy", 32'(r4), 32'd0);
      drive(1'b1, 1'b1, 8'h0F, 8'h08);
      @(negedge clk);
      s4 = 1'b0;
      @(negedge clk);
      finish("ign", 3, last_p, got);
      last_p = got;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("ign no extra op", 32'({r4, d4}), 32'b10);
      end

      // Reset two cycles into BUSY abandons the operation.
      start_op(1'b0, 8'h05, 8'h05);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset product", 32'(p4), 32'd0);
      check("midreset ready", 32'(r4), 32'd1);
      check("midreset done", 32'(d4), 32'd0);
      void'(exp_q.pop_front());
      last_p = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("midreset no done", 32'(d4), 32'd0);
      end
      op("u 6x6", 1'b0, 8'h06, 8'h06);
      check("u 6x6 const", 32'(last_p), 32'h24);

      // W=8: boundary pairs, then random signed/unsigned pairs.
      sel = 1'b1;
      last_p = '0;
      @(negedge clk);
      op("w8 s -128x-128", 1'b1, 8'h80, 8'h80);
      check("w8 s -128x-128 const", 32'(last_p), 32'h4000);
      op("w8 u 255x255", 1'b0, 8'hFF, 8'hFF);
      check("w8 u 255x255 const", 32'(last_p), 32'hFE01);
      for (int i = 0; i < 24; i++) begin
         logic       rsm;
         logic [7:0] ra, rb;
         rsm = 1'($urandom_range(0, 1));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         op($sformatf("w8 rnd%0d sm%0d %0h*%0h", i, rsm, ra, rb), rsm, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
